// File: rtl/amba_axi4_lite_pkg.sv
// amba_axi4_lite_pkg: response codes, master FSM states and protection default for the AXI4-Lite master.
package amba_axi4_lite_pkg;
  typedef enum logic [1:0] {
    OKAY   = 2'd0,
    EXOKAY = 2'd1,
    SLVERR = 2'd2,
    DECERR = 2'd3
  } resp_t;
  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP,
    DONE
  } master_state_t;
  localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;
endpackage

// File: rtl/amba_axi4_lite_master.sv
// amba_axi4_lite_master: single-outstanding AXI4-Lite initiator driven by a valid/ready command port.
module amba_axi4_lite_master
  import amba_axi4_lite_pkg::*;
#(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 5
) (
  input  logic                            ACLK,
  input  logic                            ARSTn,
  input  logic                            i_cmd_valid,
  output logic                            o_cmd_ready,
  input  logic                            i_cmd_we,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   i_cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   i_cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] i_cmd_wstrb,
  output logic                            o_rsp_valid,
  input  logic                            i_rsp_ready,
  output logic                            o_rsp_is_write,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   o_rsp_rdata,
  output logic [1:0]                      o_rsp_resp,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);
  master_state_t state;
  logic aw_done, w_done;
  logic aw_fin, w_fin, accept;
  assign M_AXI_AWPROT = AXI_PROT_DEFAULT;
  assign M_AXI_ARPROT = AXI_PROT_DEFAULT;
  assign accept = i_cmd_valid && o_cmd_ready;
  // a channel counts as finished if it handshook earlier or is handshaking now
  assign aw_fin = aw_done || (M_AXI_AWVALID && M_AXI_AWREADY);
  assign w_fin  = w_done || (M_AXI_WVALID && M_AXI_WREADY);
  always_ff @(posedge ACLK or negedge ARSTn)
    if (!ARSTn) begin
      state          <= IDLE;
      aw_done        <= 1'b0;
      w_done         <= 1'b0;
      o_cmd_ready    <= 1'b0;
      o_rsp_valid    <= 1'b0;
      o_rsp_is_write <= 1'b0;
      o_rsp_rdata    <= '0;
      o_rsp_resp     <= OKAY;
      M_AXI_AWADDR   <= '0;
      M_AXI_AWVALID  <= 1'b0;
      M_AXI_WDATA    <= '0;
      M_AXI_WSTRB    <= '0;
      M_AXI_WVALID   <= 1'b0;
      M_AXI_BREADY   <= 1'b0;
      M_AXI_ARADDR   <= '0;
      M_AXI_ARVALID  <= 1'b0;
      M_AXI_RREADY   <= 1'b0;
    end else
      case (state)
        IDLE: begin
          o_cmd_ready <= !accept;
          if (accept) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            if (i_cmd_we) begin
              M_AXI_AWADDR  <= i_cmd_addr;
              M_AXI_WDATA   <= i_cmd_wdata;
              M_AXI_WSTRB   <= i_cmd_wstrb;
              M_AXI_AWVALID <= 1'b1;
              M_AXI_WVALID  <= 1'b1;
              state         <= WR_REQ;
            end else begin
              M_AXI_ARADDR  <= i_cmd_addr;
              M_AXI_ARVALID <= 1'b1;
              state         <= RD_REQ;
            end
          end
        end
        WR_REQ: begin
          if (M_AXI_AWVALID && M_AXI_AWREADY) begin
            M_AXI_AWVALID <= 1'b0;
            aw_done       <= 1'b1;
          end
          if (M_AXI_WVALID && M_AXI_WREADY) begin
            M_AXI_WVALID <= 1'b0;
            w_done       <= 1'b1;
          end
          if (aw_fin && w_fin) begin
            M_AXI_BREADY <= 1'b1;
            state        <= WR_RESP;
          end
        end
        WR_RESP:
          if (M_AXI_BVALID) begin
            M_AXI_BREADY   <= 1'b0;
            o_rsp_resp     <= M_AXI_BRESP;
            o_rsp_is_write <= 1'b1;
            o_rsp_rdata    <= '0;
            o_rsp_valid    <= 1'b1;
            state          <= DONE;
          end
        RD_REQ:
          if (M_AXI_ARREADY) begin
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b1;
            state         <= RD_RESP;
          end
        RD_RESP:
          if (M_AXI_RVALID) begin
            M_AXI_RREADY   <= 1'b0;
            o_rsp_resp     <= M_AXI_RRESP;
            o_rsp_is_write <= 1'b0;
            o_rsp_rdata    <= M_AXI_RDATA;
            o_rsp_valid    <= 1'b1;
            state          <= DONE;
          end
        DONE:
          if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            o_cmd_ready <= 1'b1;
            state       <= IDLE;
          end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_amba_axi4_lite_master.sv
// tb_amba_axi4_lite_master: directed checks of write/read latency, stalls, error responses, backpressure and reset.
module tb_amba_axi4_lite_master;
  logic        ACLK = 1'b0;
  logic        ARSTn;
  logic        i_cmd_valid, o_cmd_ready, i_cmd_we;
  logic [4:0]  i_cmd_addr;
  logic [31:0] i_cmd_wdata;
  logic [3:0]  i_cmd_wstrb;
  logic        o_rsp_valid, i_rsp_ready, o_rsp_is_write;
  logic [31:0] o_rsp_rdata;
  logic [1:0]  o_rsp_resp;
  logic [4:0]  M_AXI_AWADDR, M_AXI_ARADDR;
  logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
  logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
  logic [31:0] M_AXI_WDATA, M_AXI_RDATA;
  logic [3:0]  M_AXI_WSTRB;
  logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
  logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
  logic        M_AXI_RVALID, M_AXI_RREADY;
  logic [31:0] mem [8];
  int checks = 0;
  int errors = 0;
  amba_axi4_lite_master dut (
    .ACLK(ACLK), .ARSTn(ARSTn),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_we(i_cmd_we),
    .i_cmd_addr(i_cmd_addr), .i_cmd_wdata(i_cmd_wdata), .i_cmd_wstrb(i_cmd_wstrb),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_is_write(o_rsp_is_write),
    .o_rsp_rdata(o_rsp_rdata), .o_rsp_resp(o_rsp_resp),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT), .M_AXI_AWVALID(M_AXI_AWVALID),
    .M_AXI_AWREADY(M_AXI_AWREADY), .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_BRESP(M_AXI_BRESP),
    .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_ARADDR(M_AXI_ARADDR),
    .M_AXI_ARPROT(M_AXI_ARPROT), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RVALID(M_AXI_RVALID),
    .M_AXI_RREADY(M_AXI_RREADY)
  );
  always #5 ACLK = ~ACLK;
  always @(posedge ACLK)
    if (M_AXI_AWVALID && M_AXI_AWREADY && M_AXI_WVALID && M_AXI_WREADY)
      mem[M_AXI_AWADDR[4:2]] <= M_AXI_WDATA;
  task automatic step();
    @(posedge ACLK);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic all_idle(input string tag);
    check({tag, " awvalid"}, M_AXI_AWVALID, 0);
    check({tag, " wvalid"}, M_AXI_WVALID, 0);
    check({tag, " bready"}, M_AXI_BREADY, 0);
    check({tag, " arvalid"}, M_AXI_ARVALID, 0);
    check({tag, " rready"}, M_AXI_RREADY, 0);
    check({tag, " rsp_valid"}, o_rsp_valid, 0);
  endtask
  initial begin
    ARSTn = 1'b0;
    i_cmd_valid = 0; i_cmd_we = 0; i_cmd_addr = '0; i_cmd_wdata = '0; i_cmd_wstrb = '0;
    i_rsp_ready = 0;
    M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0; M_AXI_BRESP = 0;
    M_AXI_ARREADY = 0; M_AXI_RVALID = 0; M_AXI_RDATA = '0; M_AXI_RRESP = 0;
    step();
    step();
    all_idle("rst");
    check("rst cmd_ready", o_cmd_ready, 0);
    check("rst awaddr", M_AXI_AWADDR, 0);
    check("rst rdata", o_rsp_rdata, 0);
    ARSTn = 1'b1;
    step();
    check("post-rst cmd_ready", o_cmd_ready, 1);
    // zero-wait write 0x04 <= 5
    i_cmd_valid = 1; i_cmd_we = 1; i_cmd_addr = 5'h04; i_cmd_wdata = 32'h5; i_cmd_wstrb = 4'hF;
    M_AXI_AWREADY = 1; M_AXI_WREADY = 1;
    step();
    check("wr c1 awvalid", M_AXI_AWVALID, 1);
    check("wr c1 wvalid", M_AXI_WVALID, 1);
    check("wr c1 awaddr", M_AXI_AWADDR, 32'h04);
    check("wr c1 wdata", M_AXI_WDATA, 32'h5);
    check("wr c1 wstrb", M_AXI_WSTRB, 4'hF);
    check("wr c1 awprot", M_AXI_AWPROT, 0);
    check("wr c1 cmd_ready", o_cmd_ready, 0);
    i_cmd_valid = 0;
    step();
    check("wr c2 awvalid", M_AXI_AWVALID, 0);
    check("wr c2 wvalid", M_AXI_WVALID, 0);
    check("wr c2 bready", M_AXI_BREADY, 1);
    check("wr slave reg", mem[1], 32'h5);
    M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 1; M_AXI_BRESP = 2'd0;
    step();
    check("wr c3 rsp_valid", o_rsp_valid, 1);
    check("wr c3 is_write", o_rsp_is_write, 1);
    check("wr c3 resp", o_rsp_resp, 0);
    check("wr c3 rdata", o_rsp_rdata, 0);
    check("wr c3 bready", M_AXI_BREADY, 0);
    M_AXI_BVALID = 0; i_rsp_ready = 1;
    step();
    check("wr c4 rsp_valid", o_rsp_valid, 0);
    check("wr c4 cmd_ready", o_cmd_ready, 1);
    // zero-wait read 0x08 -> DEADBEEF
    i_cmd_valid = 1; i_cmd_we = 0; i_cmd_addr = 5'h08; M_AXI_ARREADY = 1;
    step();
    check("rd c1 arvalid", M_AXI_ARVALID, 1);
    check("rd c1 araddr", M_AXI_ARADDR, 32'h08);
    check("rd c1 arprot", M_AXI_ARPROT, 0);
    i_cmd_valid = 0;
    step();
    check("rd c2 arvalid", M_AXI_ARVALID, 0);
    check("rd c2 rready", M_AXI_RREADY, 1);
    M_AXI_ARREADY = 0; M_AXI_RVALID = 1; M_AXI_RDATA = 32'hDEADBEEF; M_AXI_RRESP = 2'd0;
    step();
    check("rd c3 rsp_valid", o_rsp_valid, 1);
    check("rd c3 rdata", o_rsp_rdata, 32'hDEADBEEF);
    check("rd c3 resp", o_rsp_resp, 0);
    check("rd c3 is_write", o_rsp_is_write, 0);
    check("rd c3 rready", M_AXI_RREADY, 0);
    // next write queued while the response handshakes; AW stalled, W immediate
    M_AXI_RVALID = 0;
    i_cmd_valid = 1; i_cmd_we = 1; i_cmd_addr = 5'h0C; i_cmd_wdata = 32'hA5A50001; i_cmd_wstrb = 4'h3;
    M_AXI_WREADY = 1;
    step();
    check("c4 idle cmd_ready", o_cmd_ready, 1);
    check("c4 idle awvalid", M_AXI_AWVALID, 0);
    check("c4 idle rsp_valid", o_rsp_valid, 0);
    step();
    check("st c1 awvalid", M_AXI_AWVALID, 1);
    check("st c1 wvalid", M_AXI_WVALID, 1);
    check("st c1 wstrb", M_AXI_WSTRB, 4'h3);
    i_cmd_valid = 0;
    step();
    check("st c2 wvalid dropped", M_AXI_WVALID, 0);
    M_AXI_WREADY = 0;
    for (int i = 2; i <= 5; i++) begin
      check($sformatf("st c%0d awvalid", i), M_AXI_AWVALID, 1);
      check($sformatf("st c%0d awaddr", i), M_AXI_AWADDR, 32'h0C);
      check($sformatf("st c%0d bready", i), M_AXI_BREADY, 0);
      if (i == 5) M_AXI_AWREADY = 1;
      step();
    end
    check("st c6 awvalid", M_AXI_AWVALID, 0);
    check("st c6 bready", M_AXI_BREADY, 1);
    M_AXI_AWREADY = 0; M_AXI_BVALID = 1; M_AXI_BRESP = 2'd2; i_rsp_ready = 0;
    step();
    // SLVERR response held under consumer backpressure with a read waiting
    M_AXI_BVALID = 0;
    i_cmd_valid = 1; i_cmd_we = 0; i_cmd_addr = 5'h10;
    for (int i = 0; i < 10; i++) begin
      check("bp rsp_valid", o_rsp_valid, 1);
      check("bp resp", o_rsp_resp, 2);
      check("bp is_write", o_rsp_is_write, 1);
      check("bp rdata", o_rsp_rdata, 0);
      check("bp cmd_ready", o_cmd_ready, 0);
      check("bp arvalid", M_AXI_ARVALID, 0);
      step();
    end
    i_rsp_ready = 1;
    step();
    check("bp idle rsp_valid", o_rsp_valid, 0);
    check("bp idle cmd_ready", o_cmd_ready, 1);
    check("bp idle arvalid", M_AXI_ARVALID, 0);
    step();
    check("de c1 arvalid", M_AXI_ARVALID, 1);
    check("de c1 araddr", M_AXI_ARADDR, 32'h10);
    i_cmd_valid = 0; M_AXI_ARREADY = 1;
    step();
    check("de c2 rready", M_AXI_RREADY, 1);
    M_AXI_ARREADY = 0; M_AXI_RVALID = 1; M_AXI_RDATA = 32'h12345678; M_AXI_RRESP = 2'd3;
    step();
    check("de rsp_valid", o_rsp_valid, 1);
    check("de resp", o_rsp_resp, 3);
    check("de rdata", o_rsp_rdata, 32'h12345678);
    M_AXI_RVALID = 0;
    step();
    all_idle("de no retry");
    check("de idle cmd_ready", o_cmd_ready, 1);
    // reset pulse while in WR_REQ
    i_cmd_valid = 1; i_cmd_we = 1; i_cmd_addr = 5'h14; i_cmd_wdata = 32'h77;
    step();
    check("rp awvalid before", M_AXI_AWVALID, 1);
    i_cmd_valid = 0;
    #2;
    ARSTn = 1'b0;
    #1;
    all_idle("rp async");
    check("rp cmd_ready", o_cmd_ready, 0);
    #1;
    ARSTn = 1'b1;
    step();
    check("rp release cmd_ready", o_cmd_ready, 1);
    check("rp release awvalid", M_AXI_AWVALID, 0);
    i_cmd_valid = 1; i_cmd_we = 0; i_cmd_addr = 5'h00; M_AXI_ARREADY = 1;
    step();
    check("rp rd arvalid", M_AXI_ARVALID, 1);
    check("rp rd araddr", M_AXI_ARADDR, 0);
    i_cmd_valid = 0;
    step();
    check("rp rd rready", M_AXI_RREADY, 1);
    M_AXI_ARREADY = 0; M_AXI_RVALID = 1; M_AXI_RDATA = 32'hCAFE0000; M_AXI_RRESP = 2'd0;
    step();
    check("rp rd rsp_valid", o_rsp_valid, 1);
    check("rp rd rdata", o_rsp_rdata, 32'hCAFE0000);
    check("rp rd resp", o_rsp_resp, 0);
    M_AXI_RVALID = 0;
    step();
    check("rp rd done", o_rsp_valid, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
